// File: rtl/muldiv_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_seq_if
//   Bundle between instruction decode and the MUL/DIV control sequencer, plus
//   the datapath strobes the sequencer generates.
//   Request side : start, opcode, ra_sel, rb_sel        (master -> slave)
//   Status side  : busy, done, err                      (slave  -> master)
//   Datapath side: op, Rout, Yin, ZHighin, Zlowin,
//                  Zhighout, Zlowout, HIin, LOin        (slave  -> master)
//   The sequencer connects through the slave modport.
// ---------------------------------------------------------------------------
interface muldiv_ctrl_seq_if;
    logic        start;
    logic [4:0]  opcode;
    logic [3:0]  ra_sel;
    logic [3:0]  rb_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  op;
    logic [15:0] Rout;
    logic        Yin;
    logic        ZHighin;
    logic        Zlowin;
    logic        Zhighout;
    logic        Zlowout;
    logic        HIin;
    logic        LOin;

    modport master (
        output start, opcode, ra_sel, rb_sel,
        input  busy, done, err, op, Rout, Yin, ZHighin, Zlowin,
               Zhighout, Zlowout, HIin, LOin
    );

    modport slave (
        input  start, opcode, ra_sel, rb_sel,
        output busy, done, err, op, Rout, Yin, ZHighin, Zlowin,
               Zhighout, Zlowout, HIin, LOin
    );
endinterface

// File: rtl/muldiv_ctrl_seq.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_seq
//   Hardwired control sequencer for MUL and DIV. For one accepted request it
//   walks LOAD_Y -> EXEC (N cycles) -> WR_LO -> WR_HI and drives the datapath
//   strobes for each step.
//   Ports:
//     Clock - rising-edge clock
//     clear - asynchronous active-high reset
//     bus   - muldiv_ctrl_seq_if.slave (request/status handshake and strobes)
//   All strobes are decoded from registered state and latched request fields
//   only; err is a registered one-cycle flag for an illegal opcode.
// ---------------------------------------------------------------------------
module muldiv_ctrl_seq #(
    parameter logic [4:0] OP_MUL     = 5'b01010,
    parameter logic [4:0] OP_DIV     = 5'b01011,
    parameter int         MUL_CYCLES = 1,
    parameter int         DIV_CYCLES = 1
) (
    input  logic            Clock,
    input  logic            clear,
    muldiv_ctrl_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Y = 3'd1,
        EXEC   = 3'd2,
        WR_LO  = 3'd3,
        WR_HI  = 3'd4
    } state_t;

    // Counter start values: EXEC runs from N-1 down to 0.
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [4:0]  opc_r;
    logic [3:0]  ra_r;
    logic [3:0]  rb_r;
    logic        err_r;

    logic        busy_s;
    logic        done_s;
    logic [4:0]  op_s;
    logic [15:0] rout_s;
    logic        yin_s;
    logic        zload_s;
    logic        zhighout_s;
    logic        zlowout_s;
    logic        hiin_s;
    logic        loin_s;

    function automatic logic [15:0] reg_select(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    function automatic logic is_legal(input logic [4:0] code);
        return (code == OP_MUL) || (code == OP_DIV);
    endfunction

    // Sequencer state, exec counter, request latches and the err flag.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            opc_r   <= 5'd0;
            ra_r    <= 4'd0;
            rb_r    <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        if (is_legal(bus.opcode)) begin
                            opc_r   <= bus.opcode;
                            ra_r    <= bus.ra_sel;
                            rb_r    <= bus.rb_sel;
                            state_r <= LOAD_Y;
                        end else begin
                            err_r   <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD_Y: begin
                    cnt_r   <= (opc_r == OP_MUL) ? MUL_LAST : DIV_LAST;
                    state_r <= EXEC;
                end
                EXEC: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= WR_LO;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                WR_LO:   state_r <= WR_HI;
                WR_HI:   state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Moore decode of the datapath strobes; only one bus driver per state.
    always_comb begin
        busy_s     = 1'b0;
        done_s     = 1'b0;
        op_s       = 5'd0;
        rout_s     = 16'h0000;
        yin_s      = 1'b0;
        zload_s    = 1'b0;
        zhighout_s = 1'b0;
        zlowout_s  = 1'b0;
        hiin_s     = 1'b0;
        loin_s     = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            LOAD_Y: begin
                busy_s = 1'b1;
                op_s   = opc_r;
                rout_s = reg_select(ra_r);
                yin_s  = 1'b1;
            end
            EXEC: begin
                busy_s  = 1'b1;
                op_s    = opc_r;
                rout_s  = reg_select(rb_r);
                // Z captures the ALU result only on the final execute cycle.
                zload_s = (cnt_r == 4'd0);
            end
            WR_LO: begin
                busy_s    = 1'b1;
                zlowout_s = 1'b1;
                loin_s    = 1'b1;
            end
            WR_HI: begin
                busy_s     = 1'b1;
                zhighout_s = 1'b1;
                hiin_s     = 1'b1;
                done_s     = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_s;
    assign bus.done     = done_s;
    assign bus.err      = err_r;
    assign bus.op       = op_s;
    assign bus.Rout     = rout_s;
    assign bus.Yin      = yin_s;
    assign bus.ZHighin  = zload_s;
    assign bus.Zlowin   = zload_s;
    assign bus.Zhighout = zhighout_s;
    assign bus.Zlowout  = zlowout_s;
    assign bus.HIin     = hiin_s;
    assign bus.LOin     = loin_s;

endmodule

// File: doc/muldiv_ctrl_seq.md
Name: muldiv_ctrl_seq

Overview:
- Hardwired control sequencer for MUL and DIV.
- Generates the datapath strobes in order: register out to Y, register out with ALU op into Z (high and low), Z low to LO, Z high to HI.
- Replaces hand-driven control strobes with an FSM that sits between instruction decode and the data_path control inputs.
- Accepts one request at a time through a start/busy/done handshake.

Parameters:
- OP_MUL, 5'b01010, ALU op code for multiply, driven on op during execute.
- OP_DIV, 5'b01011, ALU op code for divide.
- MUL_CYCLES, 1, execute cycles for multiply (1..15).
- DIV_CYCLES, 1, execute cycles for divide (1..15).

Ports:
- Clock  in  1  system clock, rising-edge active.
- clear  in  1  asynchronous active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- opcode  in  5  requested operation; must equal OP_MUL or OP_DIV.
- ra_sel  in  4  index of first operand register (goes through Y).
- rb_sel  in  4  index of second operand register (goes direct to ALU).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse during WR_HI.
- err  out  1  one-cycle pulse the cycle after start with an illegal opcode in IDLE.
- op  out  5  ALU operation select.
- Rout  out  16  one-hot register-out enables; bit n drives Rn onto the bus.
- Yin  out  1  Y register load.
- ZHighin  out  1  Z high load.
- Zlowin  out  1  Z low load.
- Zhighout  out  1  Z high onto bus.
- Zlowout  out  1  Z low onto bus.
- HIin  out  1  HI register load.
- LOin  out  1  LO register load.

Behaviour:
- State register: updates on rising Clock. clear high forces IDLE asynchronously.
- All outputs are Moore decodes of registered state/latches except err, which is registered. No output may depend combinationally on start, opcode, ra_sel or rb_sel.
- Reset: state=IDLE, exec counter=0, latched opcode/ra/rb=0, err=0. All outputs are 0 immediately on clear (busy=0, done=0, op=0, Rout=0, all strobes 0).
- IDLE:
  - start=1 with legal opcode: latch opcode, ra_sel, rb_sel; next state LOAD_Y.
  - start=1 with illegal opcode: stay IDLE; err=1 next cycle only.
  - start=0: stay IDLE.
- LOAD_Y (1 cycle): Rout=1<<ra; Yin=1; op=latched code. Next state EXEC; counter loads N-1, where N=MUL_CYCLES or DIV_CYCLES.
- EXEC (N cycles):
  - Throughout: Rout=1<<rb; op=latched code.
  - Counter decrements each cycle.
  - ZHighin=Zlowin=1 only in the cycle where counter==0; next state WR_LO.
- WR_LO (1 cycle): Zlowout=1, LOin=1, op=0, Rout=0. Next state WR_HI.
- WR_HI (1 cycle): Zhighout=1, HIin=1, done=1. Next state IDLE.
- op: latched code in LOAD_Y and EXEC, 0 otherwise.
- Rout: exactly one bit set in LOAD_Y and EXEC, zero otherwise.
- No two bus drivers (Rout bit, Zhighout, Zlowout) are ever high in the same cycle.
- Total latency, start accepted to done: N+3 cycles. busy is high from the cycle after acceptance through WR_HI.
- start while busy (including the WR_HI cycle) is ignored; it is neither queued nor flagged. The next request is accepted in IDLE, so back-to-back requests have one idle cycle between them.
- ra_sel==rb_sel is legal (squares the register).
- Inputs changing after acceptance have no effect.
- clear mid-operation: returns to IDLE at once. No further strobes are issued; HI/LO hold whatever was already written. done is not issued.
- Data-dependent behaviour (divide by zero, sign) belongs to the ALU; the sequencer never sees data.

Test Plan:
- MUL r4*r5, default params: start=1, opcode=5'b01010, ra_sel=4, rb_sel=5 → LOAD_Y: Rout=16'h0010, Yin=1 → EXEC: Rout=16'h0020, op=01010, ZHighin=Zlowin=1 → WR_LO: Zlowout+LOin → WR_HI: Zhighout+HIin, done=1 → IDLE. With R4=12 and R5=-5 in the datapath, LO=0xFFFFFFC4 and HI=0xFFFFFFFF.
- DIV with DIV_CYCLES=4, ra=2, rb=3: op=01011 held 5 cycles (LOAD_Y + 4 EXEC). Z loads asserted only on the 4th EXEC cycle. done arrives 7 cycles after acceptance.
- start pulsed in LOAD_Y, EXEC and WR_HI with a different opcode → no change in sequence or latched values. A new start in IDLE afterwards is accepted normally.
- opcode=5'b00011 with start in IDLE → err=1 for exactly one cycle, busy stays 0, no strobes.
- clear asserted mid-EXEC (between clock edges) → all outputs 0 before the next edge, state IDLE, no done. After deassert, a MUL completes normally.
- ra_sel=rb_sel=15 MUL → Rout=16'h8000 in both LOAD_Y and EXEC. Checker confirms at most one bus driver per cycle over the whole run.
